// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader and its word packer.
// The checksum option is selected by LOADER_CHECKSUM_EN in the top-level file.
package loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * 8;
  localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);
  localparam int unsigned LEN_W          = HDR_BYTES * 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERROR
  } state_e;

  // Image larger than the instruction memory can hold.
  function automatic logic too_big(input logic [LEN_W-1:0] n, input int unsigned aw);
    return 32'(n) > (32'd1 << aw);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Assembles MSB-first stream bytes into a 32-bit word.
// full flags the cycle in which the last byte of a word is shifted in.
module word_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              clear,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              full
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [BCNT_W-1:0] cnt_q,  cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      word_d = {word_q[WORD_W-9:0], byte_in};
      cnt_d  = cnt_q + BCNT_W'(1);
    end
  end

  assign word = word_q;
  assign full = shift_en && !clear && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_e             state_q, state_d;
  logic [7:0]         len_hi_q, len_hi_d;
  logic [LEN_W-1:0]   n_q, n_d;
  logic [LEN_W-1:0]   wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               accept;
  logic               pk_shift;
  logic               pk_clear;
  logic               pk_full;
  logic [WORD_W-1:0]  pk_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  word_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .shift_en (pk_shift),
    .clear    (pk_clear),
    .byte_in  (byte_in),
    .word     (pk_word),
    .full     (pk_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      len_hi_q <= '0;
      n_q      <= '0;
      wcnt_q   <= '0;
      addr_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      n_q      <= n_d;
      wcnt_q   <= wcnt_d;
      addr_q   <= addr_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign accept = byte_valid && byte_ready;

  // Next state and datapath updates.
  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    n_d      = n_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    pk_shift = 1'b0;
    pk_clear = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        wcnt_d   = '0;
        addr_d   = '0;
        pk_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        csum_d   = '0;
`endif
        state_d  = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_hi_d = byte_in;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          n_d = {len_hi_q, byte_in};
          if (too_big({len_hi_q, byte_in}, ADDR_W)) begin
            state_d = ST_ERROR;
          end else if ({len_hi_q, byte_in} == '0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          pk_shift = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_d   = csum_q ^ byte_in;
`endif
          if (pk_full) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d = addr_q + ADDR_W'(1);
        wcnt_d = wcnt_q + LEN_W'(1);
        if ((wcnt_q + LEN_W'(1)) == n_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept) state_d = (byte_in == csum_q) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE, ST_ERROR: begin
        if (reload) begin
          wcnt_d   = '0;
          addr_d   = '0;
          pk_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_d   = '0;
`endif
          state_d  = ST_LEN_HI;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register; address and data come from flops.
  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    unique case (state_q)
      ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHK: byte_ready = 1'b1;
      ST_WRITE: mem_we = 1'b1;
      ST_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      ST_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = pk_word;

endmodule
